mem_arb: RTL and testbench
==========================

MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-003 SHALL have port ifu_req/ifu_addr  input  1/64  fetch read request and address.
REQ-004 SHALL have port ifu_gnt  output  1  one-cycle pulse: IFU request accepted.
REQ-005 SHALL have port ifu_rvalid/ifu_rdata  output  1/64  fetch response.
REQ-006 SHALL have port lsu_req/lsu_we/lsu_addr/lsu_wdata/lsu_wmask  input  1/1/64/64/8  load/store request.
REQ-007 SHALL have port lsu_gnt  output  1  one-cycle pulse: LSU request accepted.
REQ-008 SHALL have port lsu_rvalid/lsu_rdata  output  1/64  load data or store acknowledge.
REQ-009 SHALL have port flush  input  1  fetch redirect; kills the in-flight IFU transaction.
REQ-010 SHALL have port mem_valid/mem_we/mem_addr/mem_wdata/mem_wmask  output  1/1/64/64/8  downstream request.
REQ-011 SHALL have port mem_ready  input  1  downstream accepts the request when mem_valid&&mem_ready.
REQ-012 SHALL have port mem_rvalid/mem_rdata  input  1/64  downstream response, one pulse per transaction.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL implement FSM IDLE, REQ, RESP, with exactly one outstanding transaction.
REQ-015 IDLE: SHALL select a requester; the selected requester's gnt pulses that cycle; next state is REQ.
REQ-016 Selection SHALL give the LSU priority unless the starve counter equals 2 and ifu_req is high; the IFU then wins.
REQ-017 Starve counter (2 bits) SHALL increment on an LSU grant while ifu_req is high, saturate at 2, and clear on any IFU grant.
REQ-018 An IFU request SHALL NOT be granted in a cycle with flush=1.
REQ-019 On grant, addr/we/wdata/wmask SHALL be latched into registers; for IFU, we=0 and wmask=0.
REQ-020 The owner flag (IFU/LSU) SHALL be latched on grant.
REQ-021 mem_* request outputs SHALL be driven from the latched registers; mem_valid=1 only in REQ.
REQ-022 REQ: mem_valid and all fields SHALL be held stable until mem_ready.
REQ-023 REQ, on mem_ready: if mem_rvalid is also high, the response SHALL be completed that cycle and the next state is IDLE; otherwise the next state is RESP.
REQ-024 RESP: SHALL wait for mem_rvalid, complete the response, then go to IDLE.
REQ-025 Completion SHALL drive owner rvalid=1 combinationally with rdata=mem_rdata in that cycle; the non-owner rvalid SHALL stay 0.
REQ-026 flush while owner=IFU in REQ/RESP SHALL set a discard flag.
REQ-027 While the discard flag is set, or when flush coincides with completion, ifu_rvalid SHALL be suppressed.
REQ-028 The discard flag SHALL clear on return to IDLE.
REQ-029 A flushed transaction SHALL still run to mem_rvalid; the downstream request is never withdrawn.
REQ-030 flush SHALL have no effect when owner=LSU or in IDLE.
REQ-031 Grant latency SHALL be 0 cycles from request in IDLE.
REQ-032 Minimum transaction occupancy SHALL be 1 cycle in IDLE plus 1 cycle in REQ; back-to-back grants SHALL be separated by at least 2 cycles.
REQ-033 ifu_rdata/lsu_rdata SHALL equal mem_rdata when the matching rvalid is high and are don't-care otherwise.

Reset
REQ-034 rst_n low SHALL immediately (asynchronously) force: state IDLE, all gnt/rvalid/mem_valid 0, busy 0, latched fields 0, starve counter 0, discard flag 0, owner IFU.
REQ-035 Reset mid-transaction SHALL abandon it without any response; downstream recovery is outside this block.
REQ-036 After rst_n deasserts, grants SHALL begin on the first rising edge with a request.

Verification
REQ-037 ifu_req=1, addr=0x8000_0000; mem_ready=1 next cycle; mem_rvalid two cycles later with rdata=0x13 -> ifu_gnt pulse in cycle 0; mem_addr=0x8000_0000 with we=0; ifu_rvalid=1 with rdata=0x13; lsu_rvalid=0.
REQ-038 ifu_req and lsu_req both high (lsu_we=1, addr=0x8000_1000, wdata=0xDEAD, wmask=0xFF) -> LSU granted first with mem_we=1 and fields as driven; IFU granted at the next IDLE.
REQ-039 lsu_req and ifu_req held continuously -> grant sequence is LSU, LSU, IFU, LSU, LSU, IFU.
REQ-040 IFU transaction in RESP; flush=1 for one cycle; mem_rvalid 3 cycles later -> ifu_rvalid stays 0; busy drops after mem_rvalid; the next IFU request is granted normally.
REQ-041 In REQ, mem_ready and mem_rvalid are high in the same cycle -> response delivered that cycle; state is IDLE on the next cycle.
REQ-042 rst_n pulled low while in RESP, between clock edges -> mem_valid, busy and all rvalid go 0 before the next edge; a late mem_rvalid after reset produces no rvalid.

Source files
------------

// File: rtl/mem_arb_if.sv
// mem_arb_if: fetch, load/store and downstream memory bus signals of the arbiter.
interface mem_arb_if;
    logic        ifu_req;
    logic [63:0] ifu_addr;
    logic        ifu_gnt;
    logic        ifu_rvalid;
    logic [63:0] ifu_rdata;
    logic        lsu_req;
    logic        lsu_we;
    logic [63:0] lsu_addr;
    logic [63:0] lsu_wdata;
    logic [7:0]  lsu_wmask;
    logic        lsu_gnt;
    logic        lsu_rvalid;
    logic [63:0] lsu_rdata;
    logic        flush;
    logic        mem_valid;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;
    logic        busy;

    modport master (
        input  ifu_req, ifu_addr, lsu_req, lsu_we, lsu_addr, lsu_wdata, lsu_wmask,
               flush, mem_ready, mem_rvalid, mem_rdata,
        output ifu_gnt, ifu_rvalid, ifu_rdata, lsu_gnt, lsu_rvalid, lsu_rdata,
               mem_valid, mem_we, mem_addr, mem_wdata, mem_wmask, busy
    );

    modport slave (
        output ifu_req, ifu_addr, lsu_req, lsu_we, lsu_addr, lsu_wdata, lsu_wmask,
               flush, mem_ready, mem_rvalid, mem_rdata,
        input  ifu_gnt, ifu_rvalid, ifu_rdata, lsu_gnt, lsu_rvalid, lsu_rdata,
               mem_valid, mem_we, mem_addr, mem_wdata, mem_wmask, busy
    );
endinterface

// File: rtl/mem_arb.sv
// mem_arb: single-outstanding arbiter of IFU fetches and LSU loads/stores onto one memory port.
module mem_arb (
    input logic       clk,
    input logic       rst_n,
    mem_arb_if.master bus
);
    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t      state, state_nxt;
    logic [1:0]  starve;
    logic        owner_lsu, discard, g_ifu, g_lsu, done;
    logic        we_q;
    logic [63:0] addr_q, wdata_q;
    logic [7:0]  wmask_q;

    // LSU wins unless the IFU has been passed over twice and can legally be granted now
    always_comb begin
        g_lsu = state == IDLE && bus.lsu_req && !(starve == 2'd2 && bus.ifu_req && !bus.flush);
        g_ifu = state == IDLE && bus.ifu_req && !bus.flush && !g_lsu;
        done = ((state == REQ && bus.mem_ready) || state == RESP) && bus.mem_rvalid;
        state_nxt = state == IDLE ? ((g_lsu || g_ifu) ? REQ : IDLE) :
                    done ? IDLE :
                    (state == REQ && bus.mem_ready) ? RESP : state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve    <= '0;
            owner_lsu <= 1'b0;
            discard   <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wmask_q   <= '0;
        end else begin
            discard <= state_nxt != IDLE && (discard || (state != IDLE && bus.flush && !owner_lsu));
            if (g_ifu || g_lsu) begin
                owner_lsu <= g_lsu;
                addr_q    <= g_lsu ? bus.lsu_addr : bus.ifu_addr;
                we_q      <= g_lsu && bus.lsu_we;
                wdata_q   <= g_lsu ? bus.lsu_wdata : '0;
                wmask_q   <= g_lsu ? bus.lsu_wmask : '0;
            end
            if (g_ifu) starve <= '0;
            else if (g_lsu && bus.ifu_req && starve != 2'd2) starve <= starve + 2'd1;
        end
    end

    assign bus.ifu_gnt    = g_ifu;
    assign bus.lsu_gnt    = g_lsu;
    assign bus.busy       = state != IDLE;
    assign bus.mem_valid  = state == REQ;
    assign bus.mem_we     = we_q;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_wdata  = wdata_q;
    assign bus.mem_wmask  = wmask_q;
    assign bus.lsu_rvalid = done && owner_lsu;
    assign bus.ifu_rvalid = done && !owner_lsu && !discard && !bus.flush;
    assign bus.lsu_rdata  = bus.mem_rdata;
    assign bus.ifu_rdata  = bus.mem_rdata;
endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: directed checks of arbitration, starvation, flush discard and async reset.
module tb_mem_arb;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   total = 0;
    int   bad = 0;

    mem_arb_if bus ();
    mem_arb dut (.clk(clk), .rst_n(rst_n), .bus(bus.master));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // inputs change 1 time unit after the rising edge; checks follow 1 unit later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.ifu_req = 0; bus.lsu_req = 0; bus.flush = 0;
        bus.mem_ready = 0; bus.mem_rvalid = 0;
    endtask

    initial begin
        bit exp_lsu [6] = '{1, 1, 0, 1, 1, 0};
        bus.ifu_req = 0; bus.ifu_addr = '0;
        bus.lsu_req = 0; bus.lsu_we = 0; bus.lsu_addr = '0; bus.lsu_wdata = '0; bus.lsu_wmask = '0;
        bus.flush = 0; bus.mem_ready = 0; bus.mem_rvalid = 0; bus.mem_rdata = '0;
        #1 rst_n = 0;
        #1;
        chk("rst_busy", 64'(bus.busy), 0);
        chk("rst_mem_valid", 64'(bus.mem_valid), 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_ifu_rvalid", 64'(bus.ifu_rvalid), 0);
        chk("rst_lsu_gnt", 64'(bus.lsu_gnt), 0);
        #10 rst_n = 1;
        tick();

        // IFU fetch with a one-cycle gap before the response
        bus.ifu_req = 1; bus.ifu_addr = 64'h8000_0000;
        #1;
        chk("f_ifu_gnt", 64'(bus.ifu_gnt), 1);
        chk("f_lsu_gnt", 64'(bus.lsu_gnt), 0);
        tick();
        bus.ifu_req = 0; bus.mem_ready = 1;
        #1;
        chk("f_mem_valid", 64'(bus.mem_valid), 1);
        chk("f_mem_addr", bus.mem_addr, 64'h8000_0000);
        chk("f_mem_we", 64'(bus.mem_we), 0);
        chk("f_busy", 64'(bus.busy), 1);
        tick();
        bus.mem_ready = 0;
        #1;
        chk("f_resp_valid", 64'(bus.mem_valid), 0);
        chk("f_resp_rvalid", 64'(bus.ifu_rvalid), 0);
        tick();
        bus.mem_rvalid = 1; bus.mem_rdata = 64'h13;
        #1;
        chk("f_ifu_rvalid", 64'(bus.ifu_rvalid), 1);
        chk("f_ifu_rdata", bus.ifu_rdata, 64'h13);
        chk("f_lsu_rvalid", 64'(bus.lsu_rvalid), 0);
        tick();
        bus.mem_rvalid = 0;
        #1;
        chk("f_idle_busy", 64'(bus.busy), 0);

        // simultaneous requests: LSU store first, IFU at the next IDLE
        bus.ifu_req = 1; bus.ifu_addr = 64'h8000_0040;
        bus.lsu_req = 1; bus.lsu_we = 1; bus.lsu_addr = 64'h8000_1000;
        bus.lsu_wdata = 64'hDEAD; bus.lsu_wmask = 8'hFF;
        #1;
        chk("b_lsu_gnt", 64'(bus.lsu_gnt), 1);
        chk("b_ifu_gnt", 64'(bus.ifu_gnt), 0);
        tick();
        bus.lsu_req = 0; bus.mem_ready = 1; bus.mem_rvalid = 1; bus.mem_rdata = 64'h1;
        #1;
        chk("b_mem_we", 64'(bus.mem_we), 1);
        chk("b_mem_addr", bus.mem_addr, 64'h8000_1000);
        chk("b_mem_wdata", bus.mem_wdata, 64'hDEAD);
        chk("b_mem_wmask", 64'(bus.mem_wmask), 64'hFF);
        chk("b_lsu_rvalid", 64'(bus.lsu_rvalid), 1);
        chk("b_ifu_rvalid", 64'(bus.ifu_rvalid), 0);
        chk("b_ifu_gnt_req", 64'(bus.ifu_gnt), 0);
        tick();
        bus.mem_ready = 0; bus.mem_rvalid = 0;
        #1;
        chk("b_idle_busy", 64'(bus.busy), 0);
        chk("b_ifu_gnt2", 64'(bus.ifu_gnt), 1);
        tick();
        bus.ifu_req = 0;
        #1;
        chk("b_ifu_addr", bus.mem_addr, 64'h8000_0040);
        chk("b_ifu_we", 64'(bus.mem_we), 0);
        chk("b_ifu_wmask", 64'(bus.mem_wmask), 0);
        chk("b_ifu_wdata", bus.mem_wdata, 0);
        bus.mem_ready = 1; bus.mem_rvalid = 1; bus.mem_rdata = 64'h55;
        #1;
        chk("b_ifu_rvalid", 64'(bus.ifu_rvalid), 1);
        chk("b_ifu_rdata", bus.ifu_rdata, 64'h55);
        tick();
        idle_inputs();
        #1;
        chk("b_end_busy", 64'(bus.busy), 0);

        // continuous contention: LSU, LSU, IFU, LSU, LSU, IFU
        bus.ifu_req = 1; bus.lsu_req = 1; bus.lsu_we = 0;
        for (int i = 0; i < 6; i++) begin
            bus.mem_ready = 0; bus.mem_rvalid = 0;
            #1;
            chk($sformatf("s_lsu_gnt%0d", i), 64'(bus.lsu_gnt), 64'(exp_lsu[i]));
            chk($sformatf("s_ifu_gnt%0d", i), 64'(bus.ifu_gnt), 64'(!exp_lsu[i]));
            tick();
            bus.mem_ready = 1; bus.mem_rvalid = 1; bus.mem_rdata = 64'(i);
            #1;
            chk($sformatf("s_gap_gnt%0d", i), 64'(bus.lsu_gnt | bus.ifu_gnt), 0);
            chk($sformatf("s_lsu_rvalid%0d", i), 64'(bus.lsu_rvalid), 64'(exp_lsu[i]));
            tick();
        end
        idle_inputs();
        #1;

        // flush in RESP: response discarded, stall in REQ keeps fields stable
        bus.ifu_req = 1; bus.ifu_addr = 64'h100;
        #1;
        chk("x_ifu_gnt", 64'(bus.ifu_gnt), 1);
        tick();
        bus.ifu_req = 0;
        #1;
        chk("x_stall_valid", 64'(bus.mem_valid), 1);
        tick();
        bus.mem_ready = 1;
        #1;
        chk("x_held_valid", 64'(bus.mem_valid), 1);
        chk("x_held_addr", bus.mem_addr, 64'h100);
        tick();
        bus.mem_ready = 0; bus.flush = 1;
        #1;
        chk("x_flush_rvalid", 64'(bus.ifu_rvalid), 0);
        chk("x_flush_busy", 64'(bus.busy), 1);
        tick();
        bus.flush = 0;
        tick();
        tick();
        bus.mem_rvalid = 1; bus.mem_rdata = 64'h77;
        #1;
        chk("x_disc_rvalid", 64'(bus.ifu_rvalid), 0);
        chk("x_disc_busy", 64'(bus.busy), 1);
        tick();
        bus.mem_rvalid = 0;
        #1;
        chk("x_after_busy", 64'(bus.busy), 0);
        bus.ifu_req = 1; bus.ifu_addr = 64'h200;
        #1;
        chk("x_next_gnt", 64'(bus.ifu_gnt), 1);
        tick();
        bus.ifu_req = 0; bus.mem_ready = 1; bus.mem_rvalid = 1; bus.mem_rdata = 64'h99;
        #1;
        chk("x_next_rvalid", 64'(bus.ifu_rvalid), 1);
        chk("x_next_rdata", bus.ifu_rdata, 64'h99);
        tick();
        idle_inputs();

        // flush coinciding with completion, flush blocking an IFU grant, flush ignored for LSU
        bus.ifu_req = 1; bus.ifu_addr = 64'h300;
        #1;
        tick();
        bus.ifu_req = 0; bus.mem_ready = 1; bus.mem_rvalid = 1; bus.flush = 1;
        #1;
        chk("c_flush_done", 64'(bus.ifu_rvalid), 0);
        tick();
        bus.mem_ready = 0; bus.mem_rvalid = 0; bus.ifu_req = 1;
        #1;
        chk("c_flush_nogrant", 64'(bus.ifu_gnt), 0);
        bus.ifu_req = 0; bus.lsu_req = 1; bus.lsu_addr = 64'h400;
        #1;
        chk("c_lsu_gnt", 64'(bus.lsu_gnt), 1);
        tick();
        bus.lsu_req = 0; bus.mem_ready = 1; bus.mem_rvalid = 1; bus.mem_rdata = 64'hAB;
        #1;
        chk("c_lsu_rvalid", 64'(bus.lsu_rvalid), 1);
        chk("c_lsu_rdata", bus.lsu_rdata, 64'hAB);
        tick();
        idle_inputs();

        // asynchronous reset while in RESP; a late response is ignored
        bus.ifu_req = 1; bus.ifu_addr = 64'h500;
        #1;
        tick();
        bus.ifu_req = 0; bus.mem_ready = 1;
        tick();
        bus.mem_ready = 0;
        #1;
        chk("r_pre_busy", 64'(bus.busy), 1);
        #1 rst_n = 0;
        #1;
        chk("r_busy", 64'(bus.busy), 0);
        chk("r_mem_valid", 64'(bus.mem_valid), 0);
        chk("r_mem_addr", bus.mem_addr, 0);
        chk("r_ifu_rvalid", 64'(bus.ifu_rvalid), 0);
        #1 rst_n = 1;
        tick();
        bus.mem_rvalid = 1; bus.mem_rdata = 64'hEE;
        #1;
        chk("r_late_ifu", 64'(bus.ifu_rvalid), 0);
        chk("r_late_lsu", 64'(bus.lsu_rvalid), 0);
        chk("r_late_busy", 64'(bus.busy), 0);
        tick();
        idle_inputs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
